// File: rtl/ad_serial_adc_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ad_serial_adc_controller                                                   |
// | Round-robin CS_n-framed serial reader for AD7946-family SAR ADCs with a    |
// | valid/ready sample stream and sticky overrun flag.                         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ad_serial_adc_controller #(
   parameter int DATA_W      = 16,
   parameter int NUM_CH      = 2,
   parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int CLK_DIV     = 4,
   parameter int CONV_CYCLES = 160
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              mode_cont,
   input  logic              start,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic              pd_req,
   output logic              pden,
   output logic [CH_W-1:0]   chsel,
   output logic              cs_n,
   output logic              sclk,
   input  logic              sdi,
   output logic [DATA_W-1:0] m_data,
   output logic [CH_W-1:0]   m_ch,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              busy,
   output logic              overrun,
   input  logic              overrun_clr
);

   localparam int c_CNT_MAX = (CONV_CYCLES > 2 * CLK_DIV) ? CONV_CYCLES : 2 * CLK_DIV;
   localparam int c_CNT_W   = $clog2(c_CNT_MAX);
   localparam int c_BIT_W   = $clog2(DATA_W);

   localparam logic [c_CNT_W-1:0] c_CONV_LOAD = c_CNT_W'(CONV_CYCLES - 1);
   // Lead-in and first SCLK low phase run back to back as one 2*CLK_DIV low stretch.
   localparam logic [c_CNT_W-1:0] c_LEAD_LOAD = c_CNT_W'(2 * CLK_DIV - 1);
   localparam logic [c_CNT_W-1:0] c_HALF_LOAD = c_CNT_W'(CLK_DIV - 1);
   localparam logic [c_BIT_W-1:0] c_BIT_LOAD  = c_BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_CONV  = 3'd2,
      S_READ  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              r_state;
   logic [c_CNT_W-1:0]  r_cnt;
   logic [c_BIT_W-1:0]  r_bit;
   logic [DATA_W-1:0]   r_shreg;
   logic                r_sdi;
   logic                r_first;
   logic [CH_W-1:0]     r_chsel;
   logic                r_cs_n;
   logic                r_sclk;
   logic                r_pden;
   logic [DATA_W-1:0]   r_m_data;
   logic [CH_W-1:0]     r_m_ch;
   logic                r_m_valid;
   logic                r_busy;
   logic                r_overrun;

   logic [CH_W-1:0]     w_lowest;
   logic [CH_W-1:0]     w_above;
   logic                w_has_above;
   logic [CH_W-1:0]     w_next_ch;
   logic                w_launch;
   logic                w_continue;

   // Scan high to low so the last hit is the lowest qualifying bit.
   always_comb begin
      w_lowest    = '0;
      w_above     = '0;
      w_has_above = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (ch_mask[i]) begin
            w_lowest = CH_W'(i);
            if (i > int'(r_chsel)) begin
               w_above     = CH_W'(i);
               w_has_above = 1'b1;
            end
         end
      end
      w_next_ch = (w_has_above && !r_first) ? w_above : w_lowest;
   end

   assign w_launch   = enable && !pd_req && !r_pden && (|ch_mask) && (mode_cont || start);
   assign w_continue = mode_cont && enable && !pd_req && (|ch_mask);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit     <= '0;
         r_shreg   <= '0;
         r_sdi     <= 1'b0;
         r_first   <= 1'b1;
         r_chsel   <= '0;
         r_cs_n    <= 1'b1;
         r_sclk    <= 1'b0;
         r_pden    <= 1'b0;
         r_m_data  <= '0;
         r_m_ch    <= '0;
         r_m_valid <= 1'b0;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_sdi  <= sdi;
         r_pden <= pd_req;

         if (overrun_clr)
            r_overrun <= 1'b0;
         if (r_m_valid && m_ready)
            r_m_valid <= 1'b0;

         case (r_state)
            S_IDLE: begin
               r_cs_n <= 1'b1;
               r_sclk <= 1'b0;
               if (w_launch) begin
                  r_state <= S_SETUP;
                  r_busy  <= 1'b1;
               end
            end

            S_SETUP: begin
               r_chsel <= w_next_ch;
               r_first <= 1'b0;
               r_cnt   <= c_CONV_LOAD;
               r_state <= S_CONV;
            end

            S_CONV: begin
               if (r_cnt == '0) begin
                  r_state <= S_READ;
                  r_cs_n  <= 1'b0;
                  r_cnt   <= c_LEAD_LOAD;
                  r_bit   <= c_BIT_LOAD;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end

            S_READ: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else if (!r_sclk) begin
                  r_sclk <= 1'b1;
                  r_cnt  <= c_HALF_LOAD;
               end else begin
                  // Last cycle of the high phase: capture, then fall.
                  r_sclk  <= 1'b0;
                  r_shreg <= {r_shreg[DATA_W-2:0], r_sdi};
                  r_cnt   <= c_HALF_LOAD;
                  if (r_bit == '0) begin
                     r_state <= S_DONE;
                     r_cs_n  <= 1'b1;
                  end else begin
                     r_bit <= r_bit - 1'b1;
                  end
               end
            end

            S_DONE: begin
               if (!r_m_valid || m_ready) begin
                  r_m_data  <= r_shreg;
                  r_m_ch    <= r_chsel;
                  r_m_valid <= 1'b1;
               end else begin
                  r_overrun <= 1'b1;
               end
               if (w_continue) begin
                  r_state <= S_SETUP;
               end else begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_first <= 1'b1;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_cs_n  <= 1'b1;
               r_sclk  <= 1'b0;
               r_busy  <= 1'b0;
               r_first <= 1'b1;
            end
         endcase
      end
   end

   assign pden    = r_pden;
   assign chsel   = r_chsel;
   assign cs_n    = r_cs_n;
   assign sclk    = r_sclk;
   assign m_data  = r_m_data;
   assign m_ch    = r_m_ch;
   assign m_valid = r_m_valid;
   assign busy    = r_busy;
   assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_ad_serial_adc_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ad_serial_adc_controller                                                |
// | Self-checking bench with a pin-level ADC model and round-robin reference.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ad_serial_adc_controller;

   localparam int DATA_W      = 16;
   localparam int NUM_CH      = 2;
   localparam int CH_W        = 1;
   localparam int CLK_DIV     = 4;
   localparam int CONV_CYCLES = 160;
   localparam int FP          = 1 + CONV_CYCLES + CLK_DIV + 2 * CLK_DIV * DATA_W + 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              enable;
   logic              mode_cont;
   logic              start;
   logic [NUM_CH-1:0] ch_mask;
   logic              pd_req;
   logic              pden;
   logic [CH_W-1:0]   chsel;
   logic              cs_n;
   logic              sclk;
   logic              sdi = 1'b0;
   logic [DATA_W-1:0] m_data;
   logic [CH_W-1:0]   m_ch;
   logic              m_valid;
   logic              m_ready;
   logic              busy;
   logic              overrun;
   logic              overrun_clr;

   ad_serial_adc_controller #(
      .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W),
      .CLK_DIV(CLK_DIV), .CONV_CYCLES(CONV_CYCLES)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .mode_cont(mode_cont),
      .start(start), .ch_mask(ch_mask), .pd_req(pd_req), .pden(pden),
      .chsel(chsel), .cs_n(cs_n), .sclk(sclk), .sdi(sdi),
      .m_data(m_data), .m_ch(m_ch), .m_valid(m_valid), .m_ready(m_ready),
      .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // ADC pin model: MSB on CS_n fall, next bit after each SCLK fall.
   logic [DATA_W-1:0] adc_word [NUM_CH];
   logic [DATA_W-1:0] shreg;
   logic [CH_W-1:0]   frame_ch;
   logic              prev_cs   = 1'b1;
   logic              prev_sclk = 1'b0;
   bit                seen_fall;
   int frames_started = 0, frames_ended = 0, rises = 0, lead_cyc = 0;
   int hp_min = 1000000, hp_max = 0, chsel_glitch = 0, sclk_idle = 0;
   int cs_fall_cyc = 0, last_tr = 0;
   int fall_times[$];

   always @(negedge clk) begin
      if (prev_cs && !cs_n) begin
         frames_started++;
         frame_ch    = chsel;
         shreg       = adc_word[chsel];
         sdi         = shreg[DATA_W-1];
         rises       = 0;
         seen_fall   = 1'b0;
         cs_fall_cyc = cyc;
         last_tr     = cyc;
         fall_times.push_back(cyc);
      end
      if (!cs_n && chsel != frame_ch) chsel_glitch++;
      if (!prev_sclk && sclk) begin
         rises++;
         if (seen_fall) begin
            if (cyc - last_tr < hp_min) hp_min = cyc - last_tr;
            if (cyc - last_tr > hp_max) hp_max = cyc - last_tr;
         end else begin
            lead_cyc = cyc - cs_fall_cyc;
         end
         last_tr = cyc;
      end
      if (prev_sclk && !sclk) begin
         seen_fall = 1'b1;
         if (cyc - last_tr < hp_min) hp_min = cyc - last_tr;
         if (cyc - last_tr > hp_max) hp_max = cyc - last_tr;
         last_tr = cyc;
         if (!cs_n) begin
            shreg = shreg << 1;
            sdi   = shreg[DATA_W-1];
         end
      end
      if (cs_n && sclk) sclk_idle++;
      if (!prev_cs && cs_n) frames_ended++;
      prev_cs   = cs_n;
      prev_sclk = sclk;
   end

   // Next enabled channel by modular scan starting after cur (or from 0 when first).
   function automatic int rr_next(input int cur, input bit first, input logic [NUM_CH-1:0] mask);
      for (int k = 0; k < NUM_CH; k++) begin
         int c;
         c = first ? k : (cur + 1 + k) % NUM_CH;
         if (mask[c]) return c;
      end
      return 0;
   endfunction

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (m_valid) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_cs_low(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!cs_n) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      int fs;
      rst_n = 1'b0; enable = 1'b0; mode_cont = 1'b0; start = 1'b0;
      ch_mask = '0; pd_req = 1'b0; m_ready = 1'b0; overrun_clr = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (cs_n !== 1'b1)   begin n_fail++; $display("FAIL reset_cs_n got %b want 1", cs_n); end
      n_checks++; if (sclk !== 1'b0)   begin n_fail++; $display("FAIL reset_sclk got %b want 0", sclk); end
      n_checks++; if (chsel !== '0)    begin n_fail++; $display("FAIL reset_chsel got %0d want 0", chsel); end
      n_checks++; if (pden !== 1'b0)   begin n_fail++; $display("FAIL reset_pden got %b want 0", pden); end
      n_checks++; if (m_data !== '0)   begin n_fail++; $display("FAIL reset_m_data got %h want 0", m_data); end
      n_checks++; if (m_ch !== '0)     begin n_fail++; $display("FAIL reset_m_ch got %0d want 0", m_ch); end
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
      n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
      rst_n = 1'b1; enable = 1'b1; ch_mask = 2'b11;
      fs = frames_started;
      repeat (50) @(negedge clk);
      n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL idle_busy got %b want 0", busy); end
      n_checks++; if (frames_started != fs) begin n_fail++; $display("FAIL idle_frames got %0d want %0d", frames_started, fs); end
   endtask

   task automatic test_single_shot();
      bit ok;
      int fs;
      logic [NUM_CH-1:0] mask;
      logic [CH_W-1:0]   exp_ch;
      for (int it = 0; it < 5; it++) begin
         if (it == 0) begin
            mask = 2'b01;
            adc_word[0] = 16'hA5C3;
            adc_word[1] = 16'h0000;
         end else begin
            mask = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
            for (int c = 0; c < NUM_CH; c++) adc_word[c] = DATA_W'($urandom);
         end
         exp_ch  = CH_W'(rr_next(0, 1'b1, mask));
         ch_mask = mask; m_ready = 1'b0;
         hp_min = 1000000; hp_max = 0;
         fs = frames_started;
         start = 1'b1; @(negedge clk); start = 1'b0;
         wait_valid(2 * FP, ok);
         n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout got m_valid=0 want 1 (it %0d)", it); end
         n_checks++; if (m_data !== adc_word[exp_ch]) begin n_fail++; $display("FAIL single_data got %h want %h", m_data, adc_word[exp_ch]); end
         n_checks++; if (m_ch !== exp_ch) begin n_fail++; $display("FAIL single_ch got %0d want %0d", m_ch, exp_ch); end
         n_checks++; if (rises != DATA_W) begin n_fail++; $display("FAIL single_sclk_rises got %0d want %0d", rises, DATA_W); end
         n_checks++; if (hp_min != CLK_DIV || hp_max != CLK_DIV) begin n_fail++; $display("FAIL single_halfperiod got %0d..%0d want %0d", hp_min, hp_max, CLK_DIV); end
         n_checks++; if (lead_cyc != 2 * CLK_DIV) begin n_fail++; $display("FAIL single_leadin got %0d want %0d", lead_cyc, 2 * CLK_DIV); end
         wait_idle(FP, ok);
         n_checks++; if (!ok) begin n_fail++; $display("FAIL single_busy got 1 want 0"); end
         repeat (20) @(negedge clk);
         n_checks++; if (frames_started - fs != 1) begin n_fail++; $display("FAIL single_frames got %0d want 1", frames_started - fs); end
         m_ready = 1'b1; @(negedge clk); m_ready = 1'b0;
         n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL single_accept got m_valid=%b want 0", m_valid); end
      end
   endtask

   task automatic test_continuous();
      bit ok;
      int exp, n;
      logic [NUM_CH-1:0] mask;
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 0) begin
            mask = 2'b11;
            for (int c = 0; c < NUM_CH; c++) adc_word[c] = DATA_W'(32'h1000 + c);
         end else begin
            mask = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
            for (int c = 0; c < NUM_CH; c++) adc_word[c] = DATA_W'($urandom);
         end
         fall_times.delete();
         chsel_glitch = 0;
         ch_mask = mask; m_ready = 1'b1; mode_cont = 1'b1;
         exp = rr_next(0, 1'b1, mask);
         for (int s = 0; s < 4; s++) begin
            wait_valid(2 * FP, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL cont_timeout got m_valid=0 want 1 (sample %0d)", s); end
            n_checks++; if (m_ch !== CH_W'(exp)) begin n_fail++; $display("FAIL cont_ch got %0d want %0d", m_ch, exp); end
            n_checks++; if (m_data !== adc_word[exp]) begin n_fail++; $display("FAIL cont_data got %h want %h", m_data, adc_word[exp]); end
            exp = rr_next(exp, 1'b0, mask);
         end
         mode_cont = 1'b0;
         wait_idle(2 * FP, ok);
         n_checks++; if (!ok) begin n_fail++; $display("FAIL cont_stop got busy=1 want 0"); end
         n = fall_times.size();
         for (int i = 1; i < n; i++) begin
            n_checks++;
            if (fall_times[i] - fall_times[i-1] != FP) begin
               n_fail++; $display("FAIL cont_period got %0d want %0d", fall_times[i] - fall_times[i-1], FP);
            end
         end
         n_checks++; if (chsel_glitch != 0) begin n_fail++; $display("FAIL cont_chsel_stable got %0d changes want 0", chsel_glitch); end
         repeat (5) @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int fe, unstable;
      logic [DATA_W-1:0] w1;
      w1 = DATA_W'($urandom);
      ch_mask = 2'b01; m_ready = 1'b0; adc_word[0] = w1;
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL bp_overrun_init got %b want 0", overrun); end
      mode_cont = 1'b1;
      wait_valid(2 * FP, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout got m_valid=0 want 1"); end
      n_checks++; if (m_data !== w1) begin n_fail++; $display("FAIL bp_first_data got %h want %h", m_data, w1); end
      adc_word[0] = ~w1;
      mode_cont = 1'b0;
      fe = frames_ended;
      unstable = 0;
      for (int i = 0; i < 2 * FP; i++) begin
         @(negedge clk);
         if (m_data !== w1 || m_valid !== 1'b1 || m_ch !== '0) unstable++;
         if (!busy) break;
      end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle got busy=1 want 0"); end
      n_checks++; if (frames_ended - fe != 1) begin n_fail++; $display("FAIL bp_second_frame got %0d want 1", frames_ended - fe); end
      n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL bp_hold_stable got %0d bad cycles want 0", unstable); end
      n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL bp_overrun got %b want 1", overrun); end
      overrun_clr = 1'b1; @(negedge clk); overrun_clr = 1'b0;
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL bp_overrun_clr got %b want 0", overrun); end
      n_checks++; if (m_data !== w1) begin n_fail++; $display("FAIL bp_held_data got %h want %h", m_data, w1); end
      m_ready = 1'b1; @(negedge clk); m_ready = 1'b0;
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_accept got m_valid=%b want 0", m_valid); end
   endtask

   task automatic test_mid_stop();
      bit ok;
      int fs;
      ch_mask = 2'b11; m_ready = 1'b1;
      for (int c = 0; c < NUM_CH; c++) adc_word[c] = DATA_W'($urandom);
      mode_cont = 1'b1;
      wait_cs_low(2 * FP, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL stop_no_read got cs_n=1 want 0"); end
      repeat (20) @(negedge clk);
      enable = 1'b0;
      wait_valid(FP, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL stop_delivered got m_valid=0 want 1"); end
      n_checks++; if (m_data !== adc_word[0]) begin n_fail++; $display("FAIL stop_data got %h want %h", m_data, adc_word[0]); end
      n_checks++; if (m_ch !== '0) begin n_fail++; $display("FAIL stop_ch got %0d want 0", m_ch); end
      fs = frames_started;
      repeat (FP + 50) @(negedge clk);
      n_checks++; if (busy !== 1'b0 || frames_started != fs) begin n_fail++; $display("FAIL stop_idle got busy=%b frames=%0d want 0/%0d", busy, frames_started, fs); end
      mode_cont = 1'b0; enable = 1'b1;

      // Asynchronous reset in the middle of READ.
      mode_cont = 1'b1;
      wait_cs_low(2 * FP, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL areset_no_read got cs_n=1 want 0"); end
      repeat (13) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (cs_n !== 1'b1 || sclk !== 1'b0) begin n_fail++; $display("FAIL areset_pins got cs_n=%b sclk=%b want 1/0", cs_n, sclk); end
      mode_cont = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      fs = frames_started;
      ok = 1'b0;
      for (int i = 0; i < FP; i++) begin
         @(negedge clk);
         if (m_valid) ok = 1'b1;
      end
      n_checks++; if (ok) begin n_fail++; $display("FAIL areset_no_output got m_valid=1 want 0"); end
      n_checks++; if (frames_started != fs || busy !== 1'b0) begin n_fail++; $display("FAIL areset_idle got frames=%0d busy=%b want %0d/0", frames_started, busy, fs); end
   endtask

   task automatic test_power_down();
      int fs;
      ch_mask = 2'b11; mode_cont = 1'b0; enable = 1'b1;
      pd_req = 1'b1; @(negedge clk);
      n_checks++; if (pden !== 1'b1) begin n_fail++; $display("FAIL pd_pden got %b want 1", pden); end
      fs = frames_started;
      start = 1'b1; @(negedge clk); start = 1'b0;
      repeat (FP) @(negedge clk);
      n_checks++; if (busy !== 1'b0 || frames_started != fs) begin n_fail++; $display("FAIL pd_start_ignored got busy=%b frames=%0d want 0/%0d", busy, frames_started, fs); end
      pd_req = 1'b0; @(negedge clk);
      n_checks++; if (pden !== 1'b0) begin n_fail++; $display("FAIL pd_release got %b want 0", pden); end
      ch_mask = '0; mode_cont = 1'b1;
      repeat (2 * FP) @(negedge clk);
      n_checks++; if (busy !== 1'b0 || frames_started != fs) begin n_fail++; $display("FAIL mask0_no_frames got busy=%b frames=%0d want 0/%0d", busy, frames_started, fs); end
      mode_cont = 1'b0;
   endtask

   initial begin
      for (int c = 0; c < NUM_CH; c++) adc_word[c] = '0;
      test_reset();
      test_single_shot();
      test_continuous();
      test_backpressure();
      test_mid_stop();
      test_power_down();
      n_checks++; if (sclk_idle != 0) begin n_fail++; $display("FAIL sclk_outside_frame got %0d cycles want 0", sclk_idle); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
